// File: rtl/dilithium_io_pkg.sv
// Shared definitions for the Dilithium host I/O blocks (input framer and output adapter).
// Contents: mode encoding, legal security levels, operand word counts per level,
// and the input framer FSM state encoding.
package dilithium_io_pkg;

    localparam int IO_DATA_W = 64;

    typedef enum logic [1:0] {
        MODE_KEYGEN  = 2'd0,
        MODE_VERIFY  = 2'd1,
        MODE_SIGN    = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    localparam logic [2:0] SEC_LVL2 = 3'd2;
    localparam logic [2:0] SEC_LVL3 = 3'd3;
    localparam logic [2:0] SEC_LVL5 = 3'd5;

    // Operand sizes in 64-bit words.
    localparam logic [31:0] SEED_W = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIXED = 3'd1,
        ST_MLEN  = 3'd2,
        ST_MSG   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } framer_state_e;

    function automatic logic lvl_legal(input logic [2:0] lvl);
        return (lvl == SEC_LVL2) || (lvl == SEC_LVL3) || (lvl == SEC_LVL5);
    endfunction

    function automatic logic [31:0] pk_words(input logic [2:0] lvl);
        case (lvl)
            SEC_LVL2: return 32'd164;
            SEC_LVL3: return 32'd244;
            SEC_LVL5: return 32'd324;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] sk_words(input logic [2:0] lvl);
        case (lvl)
            SEC_LVL2: return 32'd316;
            SEC_LVL3: return 32'd500;
            SEC_LVL5: return 32'd608;
            default:  return 32'd0;
        endcase
    endfunction

    // The final signature word is zero-padded by the host.
    function automatic logic [31:0] sig_words(input logic [2:0] lvl);
        case (lvl)
            SEC_LVL2: return 32'd303;
            SEC_LVL3: return 32'd412;
            SEC_LVL5: return 32'd575;
            default:  return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/framer_skid_buf.sv
// Small circular buffer of {last,data} entries between the framer and the core port.
// Both handshake outputs come straight from registers, so there is no combinational
// path from the host side to the core side.
// Ports:
//   clk, rst (sync active-low)  clock / reset; reset empties the buffer and clears storage
//   flush                       drop every buffered entry
//   in_valid/in_ready/in_data/in_last     write side
//   out_valid/out_ready/out_data/out_last read side; out_last is qualified by out_valid
module framer_skid_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic [DATA_W:0]  w_head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign out_data  = w_head[DATA_W-1:0];
    assign out_last  = out_valid & w_head[DATA_W];
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {in_last, in_data};
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dilithium_input_framer.sv
// Host ingress framer: checks the host word stream against the operand layout of the
// selected mode / security level and forwards it to the core with core_last on the
// final word of the frame.
// Ports:
//   clk, rst (sync active-low)
//   start, mode[1:0], sec_lvl[2:0]       frame request (accepted in IDLE/ERR only)
//   valid_i, ready_i, data_i[63:0]       host stream
//   core_valid, core_ready, core_data, core_last   core stream
//   busy, done, error                    status (done is a 1-cycle pulse, error is sticky)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FIXED | fixed-size operands (seed, pk+sig or sk), cnt words left
// ST_MLEN  | expecting the message length word (bytes)
// ST_MSG   | message words, cnt words left
// ST_DRAIN | last word queued, waiting for the core to take it
// ST_ERR   | illegal request or mlen; error held until next start
module dilithium_input_framer
    import dilithium_io_pkg::*;
#(
    parameter int DATA_W     = IO_DATA_W,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [2:0]        sec_lvl,
    input  logic              valid_i,
    output logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [DATA_W-1:0] core_data,
    output logic              core_last,
    output logic              busy,
    output logic              done,
    output logic              error
);

    framer_state_e r_state;
    mode_e         r_mode;
    logic [31:0]   r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic          w_skid_in_ready;
    logic          w_accepting;
    logic          w_host_xfer;
    logic          w_push;
    logic          w_push_last;
    logic          w_flush;
    logic          w_start_ok;
    logic [31:0]   w_init_cnt;
    logic          w_mlen_bad;
    logic [32:0]   w_mlen_sum;
    logic [29:0]   w_mlen_words;
    logic          w_core_last_xfer;

    assign w_accepting = (r_state == ST_FIXED) || (r_state == ST_MLEN) || (r_state == ST_MSG);
    assign ready_i     = w_accepting & w_skid_in_ready;
    assign w_host_xfer = valid_i & ready_i;

    // mlen is a byte count; round up to whole words with a 33-bit sum so 2^32-1 doesn't wrap.
    assign w_mlen_bad   = |data_i[63:32];
    assign w_mlen_sum   = {1'b0, data_i[31:0]} + 33'd7;
    assign w_mlen_words = w_mlen_sum[32:3];

    // A bad mlen word is swallowed: it is not forwarded and anything queued is dropped.
    assign w_push  = w_host_xfer & ~((r_state == ST_MLEN) & w_mlen_bad);
    assign w_flush = w_host_xfer & (r_state == ST_MLEN) & w_mlen_bad;

    assign w_start_ok       = (mode != MODE_ILLEGAL) && lvl_legal(sec_lvl);
    assign w_core_last_xfer = core_valid & core_ready & core_last;

    always_comb begin
        w_init_cnt = 32'd0;
        case (mode_e'(mode))
            MODE_KEYGEN: w_init_cnt = SEED_W;
            MODE_VERIFY: w_init_cnt = pk_words(sec_lvl) + sig_words(sec_lvl);
            MODE_SIGN:   w_init_cnt = sk_words(sec_lvl);
            default:     w_init_cnt = 32'd0;
        endcase
    end

    always_comb begin
        w_push_last = 1'b0;
        case (r_state)
            ST_FIXED: w_push_last = (r_cnt == 32'd1) && (r_mode == MODE_KEYGEN);
            ST_MLEN:  w_push_last = (w_mlen_words == '0);
            ST_MSG:   w_push_last = (r_cnt == 32'd1);
            default:  w_push_last = 1'b0;
        endcase
    end

    // sec_lvl is only needed to size the fixed section, so it is consumed into r_cnt at start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_KEYGEN;
            r_cnt   <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        r_mode <= mode_e'(mode);
                        if (w_start_ok) begin
                            r_state <= ST_FIXED;
                            r_cnt   <= w_init_cnt;
                            r_busy  <= 1'b1;
                            r_error <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_cnt   <= 32'd0;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_FIXED: begin
                    if (w_host_xfer) begin
                        r_cnt <= r_cnt - 32'd1;
                        if (r_cnt == 32'd1) begin
                            r_state <= (r_mode == MODE_KEYGEN) ? ST_DRAIN : ST_MLEN;
                        end
                    end
                end
                ST_MLEN: begin
                    if (w_host_xfer) begin
                        if (w_mlen_bad) begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_cnt   <= {2'b00, w_mlen_words};
                            r_state <= (w_mlen_words == '0) ? ST_DRAIN : ST_MSG;
                        end
                    end
                end
                ST_MSG: begin
                    if (w_host_xfer) begin
                        r_cnt <= r_cnt - 32'd1;
                        if (r_cnt == 32'd1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last word is the final buffer entry, so its acceptance also empties the buffer.
                    if (w_core_last_xfer) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 32'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

    framer_skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_flush),
        .in_valid  (w_push),
        .in_ready  (w_skid_in_ready),
        .in_data   (data_i),
        .in_last   (w_push_last),
        .out_valid (core_valid),
        .out_ready (core_ready),
        .out_data  (core_data),
        .out_last  (core_last)
    );

endmodule

// File: tb/tb_dilithium_input_framer.sv
module tb_dilithium_input_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  sec_lvl;
    logic        valid_i;
    logic        ready_i;
    logic [63:0] data_i;
    logic        core_valid;
    logic        core_ready;
    logic [63:0] core_data;
    logic        core_last;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    dilithium_input_framer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .sec_lvl    (sec_lvl),
        .valid_i    (valid_i),
        .ready_i    (ready_i),
        .data_i     (data_i),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .core_data  (core_data),
        .core_last  (core_last),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: frame layout from the operand rules
    function automatic int pk_w(input int lvl);
        return (lvl == 2) ? 164 : (lvl == 3) ? 244 : 324;
    endfunction
    function automatic int sk_w(input int lvl);
        return (lvl == 2) ? 316 : (lvl == 3) ? 500 : 608;
    endfunction
    function automatic int sig_w(input int lvl);
        return (lvl == 2) ? 303 : (lvl == 3) ? 412 : 575;
    endfunction

    logic [63:0] tx[$];

    function automatic void build_frame(input int m, input int lvl, input longint mlen);
        int nfix;
        tx.delete();
        nfix = (m == 0) ? 4 : (m == 1) ? pk_w(lvl) + sig_w(lvl) : sk_w(lvl);
        for (int i = 0; i < nfix; i++) tx.push_back({$urandom, $urandom});
        if (m != 0) begin
            tx.push_back(64'(mlen));
            for (longint i = 0; i < (mlen + 7) / 8; i++) tx.push_back({$urandom, $urandom});
        end
    endfunction

    // ---------------- monitor
    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } beat_t;

    beat_t       got[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_acc_cyc = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [64:0] prev_beat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !(core_valid && ({core_last, core_data} == prev_beat))) stab_err++;
                if (core_valid && core_ready) begin
                    got.push_back({core_last, core_data});
                    if (core_last) last_acc_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = core_valid && !core_ready;
                prev_beat  = {core_last, core_data};
            end
        end
    end

    int ready_pct = 100;
    initial begin
        core_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_ready = ($urandom_range(99) < ready_pct);
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks (all entered/left at posedge+1)
    task automatic do_start(input int m, input int lvl);
        got.delete();
        done_cnt = 0;
        start    = 1'b1;
        mode     = 2'(m);
        sec_lvl  = 3'(lvl);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_words(input int first, input int n_send, input int valid_pct, output int stalls);
        int  idx;
        int  guard;
        logic hs;
        idx    = first;
        guard  = 0;
        stalls = 0;
        while (idx < n_send) begin
            valid_i = ($urandom_range(99) < valid_pct);
            data_i  = tx[idx];
            @(negedge clk);
            hs = valid_i && ready_i;
            if (valid_i && !ready_i) stalls++;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                guard = 0;
            end else begin
                guard++;
            end
            if (guard > 5000) begin
                check("host_accept_timeout", 64'(idx), 64'(n_send));
                break;
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_frame(input string name, input int n);
        int mism;
        int lim;
        mism = 0;
        lim  = (got.size() < n) ? got.size() : n;
        check({name, "_len"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < lim; i++) begin
            if (got[i].data !== tx[i] || got[i].last !== (i == n - 1)) mism++;
        end
        check({name, "_word_mismatch"}, 64'(mism), 64'd0);
        check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, "_done_lat"}, 64'(done_cyc - last_acc_cyc), 64'd1);
        check({name, "_busy_after"}, {63'd0, busy}, 64'd0);
        check({name, "_ready_after"}, {63'd0, ready_i}, 64'd0);
    endtask

    // ---------------- table of frame requests
    typedef struct {
        int     m;
        int     lvl;
        longint mlen;
        int     exp_len;
        logic   exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int stalls;
        int n;
        int m;
        int lvl;
        longint mlen;

        vecs[0] = '{2, 3, 13, 503, 1'b0};
        vecs[1] = '{1, 5, 0, 900, 1'b0};
        vecs[2] = '{1, 2, 8, 469, 1'b0};
        vecs[3] = '{3, 2, 0, 0, 1'b1};
        vecs[4] = '{2, 5, 17, 612, 1'b0};
        vecs[5] = '{0, 4, 0, 0, 1'b1};
        vecs[6] = '{0, 5, 0, 4, 1'b0};
        vecs[7] = '{1, 7, 0, 0, 1'b1};
        vecs[8] = '{2, 2, 64, 325, 1'b0};
        vecs[9] = '{3, 5, 0, 0, 1'b1};

        rst     = 1'b0;
        start   = 1'b0;
        mode    = 2'd0;
        sec_lvl = 3'd0;
        valid_i = 1'b0;
        data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, ready_i}, 64'd0);
        check("rst_core_valid", {63'd0, core_valid}, 64'd0);
        check("rst_core_data", core_data, 64'd0);
        check("rst_core_last", {63'd0, core_last}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // keygen lvl2 by hand: host word alongside start is refused, first-word latency is 1
        ready_pct = 100;
        tx.delete();
        for (int i = 1; i <= 4; i++) tx.push_back(64'(i));
        got.delete();
        done_cnt = 0;
        valid_i  = 1'b1;
        data_i   = 64'hdead;
        start    = 1'b1;
        mode     = 2'd0;
        sec_lvl  = 3'd2;
        @(negedge clk);
        check("idle_start_ready", {63'd0, ready_i}, 64'd0);
        @(posedge clk);
        #1;
        start  = 1'b0;
        data_i = tx[0];
        @(negedge clk);
        check("kg_first_ready", {63'd0, ready_i}, 64'd1);
        @(posedge clk);
        #1;
        check("kg_first_latency_valid", {63'd0, core_valid}, 64'd1);
        check("kg_first_latency_data", core_data, 64'd1);
        send_words(1, 4, 100, stalls);
        wait_done(200);
        check_frame("keygen", 4);

        // table-driven frames at full rate
        for (int v = 0; v < 10; v++) begin
            do_start(vecs[v].m, vecs[v].lvl);
            if (vecs[v].exp_err) begin
                check($sformatf("v%0d_error", v), {63'd0, error}, 64'd1);
                check($sformatf("v%0d_ready", v), {63'd0, ready_i}, 64'd0);
                check($sformatf("v%0d_busy", v), {63'd0, busy}, 64'd0);
            end else begin
                check($sformatf("v%0d_error_clear", v), {63'd0, error}, 64'd0);
                check($sformatf("v%0d_busy", v), {63'd0, busy}, 64'd1);
                build_frame(vecs[v].m, vecs[v].lvl, vecs[v].mlen);
                send_words(0, tx.size(), 100, stalls);
                check($sformatf("v%0d_host_stalls", v), 64'(stalls), 64'd0);
                wait_done(200);
                check_frame($sformatf("v%0d", v), vecs[v].exp_len);
            end
        end

        // sign lvl2 with 30% core_ready and random valid_i
        ready_pct = 30;
        mlen = longint'($urandom_range(300));
        do_start(2, 2);
        build_frame(2, 2, mlen);
        n = tx.size();
        send_words(0, n, 60, stalls);
        wait_done(4000);
        check_frame("rand_sign2", sk_w(2) + 1 + int'((mlen + 7) / 8));

        // a few random legal frames with random throttling on both sides
        for (int r = 0; r < 4; r++) begin
            m         = $urandom_range(2);
            lvl       = ($urandom_range(2) == 0) ? 2 : ($urandom_range(1) == 0) ? 3 : 5;
            mlen      = longint'($urandom_range(100));
            ready_pct = 30 + $urandom_range(70);
            do_start(m, lvl);
            build_frame(m, lvl, mlen);
            send_words(0, tx.size(), 40 + $urandom_range(60), stalls);
            wait_done(4000);
            n = (m == 0) ? 4 : ((m == 1) ? pk_w(lvl) + sig_w(lvl) : sk_w(lvl)) + 1 + int'((mlen + 7) / 8);
            check_frame($sformatf("rand%0d", r), n);
        end
        check("core_stable_while_stalled", 64'(stab_err), 64'd0);

        // mlen with high bits set -> error, not forwarded
        ready_pct = 100;
        repeat (2) @(posedge clk);
        #1;
        do_start(2, 2);
        build_frame(2, 2, 0);
        tx[316] = 64'h1_0000_0000;
        send_words(0, 317, 100, stalls);
        check("mlen_hi_error", {63'd0, error}, 64'd1);
        check("mlen_hi_ready", {63'd0, ready_i}, 64'd0);
        check("mlen_hi_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mlen_hi_core_valid", {63'd0, core_valid}, 64'd0);
        check("mlen_hi_forwarded", 64'(got.size()), 64'd316);

        // valid start clears error, then reset in the middle of MSG
        do_start(2, 2);
        check("restart_error_clear", {63'd0, error}, 64'd0);
        build_frame(2, 2, 40);
        send_words(0, 319, 100, stalls);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", {63'd0, ready_i}, 64'd0);
        check("midrst_core_valid", {63'd0, core_valid}, 64'd0);
        check("midrst_core_data", core_data, 64'd0);
        check("midrst_core_last", {63'd0, core_last}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_error", {63'd0, error}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // recovery after reset
        do_start(0, 3);
        build_frame(0, 3, 0);
        send_words(0, 4, 100, stalls);
        wait_done(200);
        check_frame("post_reset_keygen", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
